// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache.
// Contents:
//   ICACHE_FRAMES, ICACHE_IDX_W, ICACHE_TAG_W - fixed direct-mapped geometry
//   icache_frame_t                           - one cache frame (valid, tag, data)
//   icache_state_t                           - instruction cache controller states
//   icache_tag / icache_idx / icache_word_addr - address field helpers
package cpu_types_pkg;

    localparam int ICACHE_FRAMES = 16;
    localparam int ICACHE_IDX_W  = 4;
    localparam int ICACHE_TAG_W  = 26;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Address layout: tag [31:6], index [5:2], byte offset [1:0].
    function automatic logic [ICACHE_TAG_W-1:0] icache_tag(input logic [31:0] addr);
        return addr[31:6];
    endfunction

    function automatic logic [ICACHE_IDX_W-1:0] icache_idx(input logic [31:0] addr);
        return addr[5:2];
    endfunction

    function automatic logic [31:0] icache_word_addr(input logic [ICACHE_TAG_W-1:0] tag,
                                                     input logic [ICACHE_IDX_W-1:0] idx);
        return {tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with 16 one-word frames.
// Hits are returned combinationally in the same cycle as the request; a miss
// latches the request address and fetches one word from memory control.
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   imemREN, imemaddr     datapath read request and word address (datapath_cache_if, icache side)
//   ihit, imemload        hit strobe and instruction word to the datapath
//   iREN, iaddr           memory read request and word address (caches_if, icache side)
//   iwait, iload          memory busy flag and read data
//
// state | meaning
// IDLE  | serve hits, on a miss latch {tag,index} and go fetch
// FETCH | hold iREN until memory drops iwait, then fill the frame
module icache_direct
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    icache_state_t             state;
    logic [ICACHE_TAG_W-1:0]   miss_tag;
    logic [ICACHE_IDX_W-1:0]   miss_idx;
    logic                      ren_q;

    logic [ICACHE_FRAMES-1:0]  valid_q;
    logic [ICACHE_TAG_W-1:0]   tag_q  [ICACHE_FRAMES];
    logic [31:0]               data_q [ICACHE_FRAMES];

    logic [ICACHE_TAG_W-1:0]   req_tag;
    logic [ICACHE_IDX_W-1:0]   req_idx;
    icache_frame_t             rd_frame;
    logic                      lookup_hit;
    logic                      fill;
    logic                      unused_byte_off;

    assign req_tag = icache_tag(imemaddr);
    assign req_idx = icache_idx(imemaddr);

    // Instruction fetches are always whole words.
    assign unused_byte_off = ^imemaddr[1:0];

    assign rd_frame = '{valid: valid_q[req_idx], tag: tag_q[req_idx], data: data_q[req_idx]};

    assign lookup_hit = (state == IDLE) && imemREN && rd_frame.valid && (rd_frame.tag == req_tag);
    assign fill       = (state == FETCH) && !iwait;

    assign ihit     = lookup_hit;
    assign imemload = lookup_hit ? rd_frame.data : '0;
    assign iREN     = ren_q;
    assign iaddr    = ren_q ? icache_word_addr(miss_tag, miss_idx) : '0;

    // The fill always completes with the latched miss address, whatever the
    // datapath does with imemaddr/imemREN meanwhile.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            miss_tag <= '0;
            miss_idx <= '0;
            ren_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !lookup_hit) begin
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        ren_q    <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        ren_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ren_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[miss_idx] <= 1'b1;
        end
    end

    // Tag and data are qualified by valid, so they carry no reset.
    // A fill replaces the resident frame outright: nothing is ever dirty.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        int          cycles;
    } fetch_t;

    logic [31:0] sb_data [$];
    fetch_t      sb_fetch [$];

    int     mem_lat;
    int     mem_cnt;
    logic   mon_prev;
    int     mon_cnt;
    fetch_t mon_cur;

    icache_direct dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2402_0001;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory control model: iwait held for mem_lat cycles of iREN, then data.
    initial begin
        mem_cnt = 0;
        iwait   = 1'b1;
        iload   = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (iREN) begin
                if (mem_cnt < mem_lat) begin
                    iwait = 1'b1;
                    iload = '0;
                end else begin
                    iwait = 1'b0;
                    iload = mem_word(iaddr);
                end
                mem_cnt++;
            end else begin
                mem_cnt = 0;
                iwait   = 1'b1;
                iload   = '0;
            end
        end
    end

    // Monitor: pops expected hit data on ihit, expected fetch on iREN rise.
    initial begin
        mon_prev = 1'b0;
        mon_cnt  = 0;
        mon_cur.addr   = '0;
        mon_cur.cycles = 0;
        forever begin
            @(negedge CLK);
            if (ihit) begin
                check1("hit_iren_low", iREN, 1'b0);
                if (sb_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit: ihit=1 imemload=%h, expected no hit", imemload);
                end else begin
                    check32("hit_data", imemload, sb_data.pop_front());
                end
            end else begin
                check32("nohit_load_zero", imemload, 32'h0);
            end
            if (iREN) begin
                if (!mon_prev) begin
                    mon_cnt = 0;
                    if (sb_fetch.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: iaddr=%h, expected no fetch", iaddr);
                        mon_cur.addr   = iaddr;
                        mon_cur.cycles = 0;
                    end else begin
                        mon_cur = sb_fetch.pop_front();
                    end
                end
                mon_cnt++;
                check32("fetch_addr", iaddr, mon_cur.addr);
            end else begin
                check32("idle_iaddr_zero", iaddr, 32'h0);
                if (mon_prev) check32("fetch_cycles", mon_cnt, mon_cur.cycles);
            end
            mon_prev = iREN;
        end
    end

    // Called at posedge+1; returns at the negedge on which ihit is seen.
    task automatic wait_hit(input int exp_n, input string name);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (n <= 60) begin
            @(negedge CLK);
            if (ihit) begin
                got = 1'b1;
                break;
            end
            n++;
            @(posedge CLK);
            #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ihit within %0d cycles, required after %0d", name, n, exp_n);
        end else begin
            check32({name, "_latency"}, n, exp_n);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input int lat, input bit miss, input string name);
        logic [31:0] wa;
        fetch_t      f;
        wa = {addr[31:2], 2'b00};
        mem_lat = lat;
        sb_data.push_back(mem_word(wa));
        if (miss) begin
            f.addr   = wa;
            f.cycles = lat + 1;
            sb_fetch.push_back(f);
        end
        imemREN  = 1'b1;
        imemaddr = addr;
        wait_hit(miss ? lat + 2 : 0, name);
        @(posedge CLK);
        #1;
        imemREN  = 1'b0;
        imemaddr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fetch_t f;
        checks   = 0;
        errors   = 0;
        mem_lat  = 1;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;

        repeat (2) @(posedge CLK);
        #1;
        check1 ("rst_ihit",     ihit,     1'b0);
        check32("rst_imemload", imemload, 32'h0);
        check1 ("rst_iren",     iREN,     1'b0);
        check32("rst_iaddr",    iaddr,    32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // cold miss with two wait cycles, then a same-cycle hit
        do_req(32'h0000_0000, 2, 1'b1, "cold_miss");
        do_req(32'h0000_0000, 0, 1'b0, "hit0");

        // no request: no hit, no fetch, nothing changes
        imemaddr = 32'h0000_0000;
        repeat (3) @(posedge CLK);
        #1;
        check1("idle_no_hit",  ihit, 1'b0);
        check1("idle_no_iren", iREN, 1'b0);
        imemaddr = '0;

        // conflict on index 1
        do_req(32'h0000_0004, 1, 1'b1, "fill4");
        do_req(32'h0000_0004, 1, 1'b0, "hit4");
        do_req(32'h0000_0044, 1, 1'b1, "conflict44");
        do_req(32'h0000_0044, 1, 1'b0, "hit44");
        do_req(32'h0000_0004, 3, 1'b1, "refill4");
        do_req(32'h0000_0000, 1, 1'b0, "hit0_again");

        // byte offset ignored
        do_req(32'h0000_0008, 1, 1'b1, "fill8");
        do_req(32'h0000_000B, 1, 1'b0, "byte_off");

        // all-ones tag, zero-latency memory, evicts frame 1
        do_req(32'hFFFF_FFC4, 0, 1'b1, "high_tag");
        do_req(32'hFFFF_FFC4, 0, 1'b0, "high_tag_hit");
        do_req(32'h0000_0004, 0, 1'b1, "evicted4");

        // address changes from 0x10 to 0x20 while fetching 0x10
        mem_lat = 3;
        f.addr = 32'h10; f.cycles = 4; sb_fetch.push_back(f);
        f.addr = 32'h20; f.cycles = 4; sb_fetch.push_back(f);
        sb_data.push_back(mem_word(32'h20));
        imemREN  = 1'b1;
        imemaddr = 32'h10;
        @(posedge CLK);
        #1;
        imemaddr = 32'h20;
        wait_hit(9, "addr_change");
        @(posedge CLK);
        #1;
        imemREN  = 1'b0;
        imemaddr = '0;
        do_req(32'h0000_0010, 1, 1'b0, "hit10_after_change");
        do_req(32'h0000_0020, 1, 1'b0, "hit20_after_change");

        // reset in the middle of a fill
        mem_lat = 10;
        f.addr = 32'h30; f.cycles = 2; sb_fetch.push_back(f);
        sb_data.push_back(mem_word(32'h30));
        imemREN  = 1'b1;
        imemaddr = 32'h30;
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check1("midfill_iren_before", iREN, 1'b1);
        nRST = 1'b0;
        #1;
        check1 ("midfill_rst_iren",  iREN,     1'b0);
        check32("midfill_rst_iaddr", iaddr,    32'h0);
        check1 ("midfill_rst_ihit",  ihit,     1'b0);
        check32("midfill_rst_load",  imemload, 32'h0);
        sb_data.delete();
        imemREN  = 1'b0;
        imemaddr = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        do_req(32'h0000_0000, 1, 1'b1, "post_reset_miss0");
        do_req(32'h0000_0030, 0, 1'b1, "post_reset_miss30");
        do_req(32'h0000_0030, 0, 1'b0, "post_reset_hit30");

        repeat (2) @(posedge CLK);
        #1;
        check32("sb_data_drained",  sb_data.size(),  32'h0);
        check32("sb_fetch_drained", sb_fetch.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
